// File: rtl/exe_stage_ctrl_pkg.sv
// Shared widths, ALU op bit indices and the execute-stage state encoding.
// Consumed by the execute-stage controller, its bus interface and its bench.
package exe_stage_ctrl_pkg;

    localparam int DATA_W   = 32;
    localparam int REG_W    = 5;
    localparam int ALU_OP_W = 19;

    localparam int ALU_OP_ADD  = 0;
    localparam int ALU_OP_SUB  = 1;
    localparam int ALU_OP_DIV  = 15;
    localparam int ALU_OP_DIVU = 16;
    localparam int ALU_OP_MOD  = 17;
    localparam int ALU_OP_MODU = 18;

    typedef enum logic [1:0] {
        ES_EMPTY = 2'd0,
        ES_EXEC  = 2'd1,
        ES_HOLD  = 2'd2,
        ES_DRAIN = 2'd3
    } es_state_e;

    // True for any op that goes through the multi-cycle divider.
    function automatic logic is_div_op(input logic [ALU_OP_W-1:0] op);
        return op[ALU_OP_DIV] | op[ALU_OP_DIVU] | op[ALU_OP_MOD] | op[ALU_OP_MODU];
    endfunction

endpackage

// File: rtl/exe_stage_ctrl_if.sv
// Execute-stage bus: decode-side request, ALU drive/return, memory-stage handoff
// and decode bypass. The controller takes the master view, its environment the slave view.
interface exe_stage_ctrl_if;
    import exe_stage_ctrl_pkg::*;

    logic                ds_to_es_valid;
    logic [ALU_OP_W-1:0] ds_alu_op;
    logic [DATA_W-1:0]   ds_src1;
    logic [DATA_W-1:0]   ds_src2;
    logic [REG_W-1:0]    ds_dest;
    logic                ds_gr_we;
    logic [DATA_W-1:0]   ds_pc;
    logic                es_allowin;

    logic [ALU_OP_W-1:0] alu_op_out;
    logic [DATA_W-1:0]   alu_src1_out;
    logic [DATA_W-1:0]   alu_src2_out;
    logic [DATA_W-1:0]   alu_result;
    logic                alu_flag;

    logic                ms_allowin;
    logic                es_to_ms_valid;
    logic [DATA_W-1:0]   es_result;
    logic [REG_W-1:0]    es_dest;
    logic                es_gr_we;
    logic [DATA_W-1:0]   es_pc;

    logic                flush;
    logic [REG_W-1:0]    es_fwd_dest;
    logic                es_fwd_ready;
    logic [DATA_W-1:0]   es_fwd_data;

    modport master (
        input  ds_to_es_valid, ds_alu_op, ds_src1, ds_src2, ds_dest, ds_gr_we, ds_pc,
        input  alu_result, alu_flag, ms_allowin, flush,
        output es_allowin, alu_op_out, alu_src1_out, alu_src2_out,
        output es_to_ms_valid, es_result, es_dest, es_gr_we, es_pc,
        output es_fwd_dest, es_fwd_ready, es_fwd_data
    );

    modport slave (
        output ds_to_es_valid, ds_alu_op, ds_src1, ds_src2, ds_dest, ds_gr_we, ds_pc,
        output alu_result, alu_flag, ms_allowin, flush,
        input  es_allowin, alu_op_out, alu_src1_out, alu_src2_out,
        input  es_to_ms_valid, es_result, es_dest, es_gr_we, es_pc,
        input  es_fwd_dest, es_fwd_ready, es_fwd_data
    );

endinterface

// File: rtl/exe_stage_ctrl.sv
// LoongArch execute-stage controller: registers one instruction, waits on the ALU,
// holds the result under backpressure and drains a flushed divide. Macro ES_BYPASS_EN enables bypass data.
module exe_stage_ctrl
    import exe_stage_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    exe_stage_ctrl_if.master bus
);

    es_state_e           state_p0;
    es_state_e           state_nxt;

    logic [ALU_OP_W-1:0] op_p0;
    logic [DATA_W-1:0]   src1_p0;
    logic [DATA_W-1:0]   src2_p0;
    logic [REG_W-1:0]    dest_p0;
    logic                gr_we_p0;
    logic [DATA_W-1:0]   pc_p0;
    logic [DATA_W-1:0]   res_p0;

    logic                st_empty;
    logic                st_exec;
    logic                st_hold;
    logic                st_drain;
    logic                done;
    logic                handoff;
    logic                allowin;
    logic                accept;
    logic                capture;

    logic [ALU_OP_W-1:0] alu_op_drv;
    logic [DATA_W-1:0]   result_drv;
    logic [REG_W-1:0]    fwd_dest_drv;

    assign st_empty = (state_p0 == ES_EMPTY);
    assign st_exec  = (state_p0 == ES_EXEC);
    assign st_hold  = (state_p0 == ES_HOLD);
    assign st_drain = (state_p0 == ES_DRAIN);

    assign done     = (st_exec & bus.alu_flag) | st_hold;
    assign handoff  = done & bus.ms_allowin;
    // Held low during reset so the stage only opens once reset is released.
    assign allowin  = ~reset & (st_empty | handoff) & ~st_drain;
    assign accept   = bus.ds_to_es_valid & allowin & ~bus.flush;
    assign capture  = st_exec & bus.alu_flag & ~bus.ms_allowin & ~bus.flush;

    // ---- stage p0: state register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state_p0 <= ES_EMPTY;
        end else begin
            state_p0 <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_p0;
        unique case (state_p0)
            ES_EMPTY: begin
                if (accept) begin
                    state_nxt = ES_EXEC;
                end
            end
            ES_EXEC: begin
                if (bus.flush) begin
                    // A divide still in flight must finish before the ALU is free again.
                    state_nxt = bus.alu_flag ? ES_EMPTY : ES_DRAIN;
                end else if (bus.alu_flag) begin
                    if (bus.ms_allowin) begin
                        state_nxt = accept ? ES_EXEC : ES_EMPTY;
                    end else begin
                        state_nxt = ES_HOLD;
                    end
                end
            end
            ES_HOLD: begin
                if (bus.flush) begin
                    state_nxt = ES_EMPTY;
                end else if (bus.ms_allowin) begin
                    state_nxt = accept ? ES_EXEC : ES_EMPTY;
                end
            end
            ES_DRAIN: begin
                if (bus.alu_flag) begin
                    state_nxt = ES_EMPTY;
                end
            end
            default: state_nxt = ES_EMPTY;
        endcase
    end

    // ---- stage p0: instruction and captured-result registers ----
    always_ff @(posedge clk) begin
        if (reset) begin
            op_p0    <= '0;
            src1_p0  <= '0;
            src2_p0  <= '0;
            dest_p0  <= '0;
            gr_we_p0 <= 1'b0;
            pc_p0    <= '0;
            res_p0   <= '0;
        end else begin
            if (accept) begin
                op_p0    <= bus.ds_alu_op;
                src1_p0  <= bus.ds_src1;
                src2_p0  <= bus.ds_src2;
                dest_p0  <= bus.ds_dest;
                gr_we_p0 <= bus.ds_gr_we;
                pc_p0    <= bus.ds_pc;
            end
            if (capture) begin
                res_p0 <= bus.alu_result;
            end
        end
    end

    // Op is withdrawn in HOLD so the divider never sees the same request twice.
    always_comb begin
        alu_op_drv   = '0;
        result_drv   = '0;
        fwd_dest_drv = '0;
        unique case (state_p0)
            ES_EXEC: begin
                alu_op_drv   = op_p0;
                result_drv   = bus.alu_result;
                fwd_dest_drv = gr_we_p0 ? dest_p0 : '0;
            end
            ES_HOLD: begin
                result_drv   = res_p0;
                fwd_dest_drv = gr_we_p0 ? dest_p0 : '0;
            end
            ES_DRAIN: begin
                alu_op_drv   = op_p0;
            end
            default: begin
                alu_op_drv   = '0;
            end
        endcase
    end

    assign bus.es_allowin     = allowin;
    assign bus.alu_op_out     = alu_op_drv;
    assign bus.alu_src1_out   = src1_p0;
    assign bus.alu_src2_out   = src2_p0;
    assign bus.es_to_ms_valid = done;
    assign bus.es_result      = result_drv;
    assign bus.es_dest        = dest_p0;
    assign bus.es_gr_we       = gr_we_p0;
    assign bus.es_pc          = pc_p0;
    assign bus.es_fwd_dest    = fwd_dest_drv;

`ifdef ES_BYPASS_EN
    assign bus.es_fwd_ready   = done & gr_we_p0;
    assign bus.es_fwd_data    = result_drv;
`else
    // Destination is still published so decode stalls on the hazard instead.
    assign bus.es_fwd_ready   = 1'b0;
    assign bus.es_fwd_data    = '0;
`endif

endmodule

// File: tb/tb_exe_stage_ctrl.sv
// Bench for exe_stage_ctrl: directed scenarios then random traffic, checked against
// a transaction-level occupancy model with results computed by plain arithmetic.
module tb_exe_stage_ctrl;
    import exe_stage_ctrl_pkg::*;

    localparam logic [18:0] OP_ADD  = 19'h00001;
    localparam logic [18:0] OP_SUB  = 19'h00002;
    localparam logic [18:0] OP_DIV  = 19'h08000;
    localparam logic [18:0] OP_DIVU = 19'h10000;
    localparam logic [18:0] OP_MOD  = 19'h20000;
    localparam logic [18:0] OP_MODU = 19'h40000;

    typedef struct {
        logic [18:0] op;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [4:0]  dest;
        logic        we;
        logic [31:0] pc;
    } inst_t;

    logic clk = 1'b0;
    logic reset;
    exe_stage_ctrl_if bus();

    exe_stage_ctrl dut (.clk(clk), .reset(reset), .bus(bus.master));

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    function automatic logic [31:0] ref_alu(input logic [18:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[ALU_OP_ADD])  return a + b;
        if (op[ALU_OP_SUB])  return a - b;
        if (op[ALU_OP_DIV])  return $signed(a) / $signed(b);
        if (op[ALU_OP_DIVU]) return a / b;
        if (op[ALU_OP_MOD])  return $signed(a) % $signed(b);
        if (op[ALU_OP_MODU]) return a % b;
        return 32'd0;
    endfunction

    // Stand-in ALU: divides start when requested while idle and flag once after 1..4 cycles.
    int          div_cnt    = 0;
    int          div_issues = 0;
    logic [31:0] div_res    = '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= 0;
        end else if (div_cnt == 0 && is_div_op(bus.alu_op_out)) begin
            div_cnt    <= $urandom_range(1, 4);
            div_res    <= ref_alu(bus.alu_op_out, bus.alu_src1_out, bus.alu_src2_out);
            div_issues <= div_issues + 1;
        end else if (div_cnt != 0) begin
            div_cnt <= div_cnt - 1;
        end
    end

    always_comb begin
        bus.alu_flag   = 1'b1;
        bus.alu_result = ref_alu(bus.alu_op_out, bus.alu_src1_out, bus.alu_src2_out);
        if (is_div_op(bus.alu_op_out)) begin
            bus.alu_flag   = (div_cnt == 1);
            bus.alu_result = (div_cnt == 1) ? div_res : 32'd0;
        end
    end

    // Reference model: does the stage hold an instruction, was it cancelled, is its result parked.
    bit    m_occ, m_cancel, m_held;
    inst_t m_inst, m_in;
    bit    s_flag, s_ready, s_allowin, s_accept;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    endtask

    task automatic set_ds(input bit v, input logic [18:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] d, input bit we, input logic [31:0] pc);
        bus.ds_to_es_valid = v;
        bus.ds_alu_op      = op;
        bus.ds_src1        = a;
        bus.ds_src2        = b;
        bus.ds_dest        = d;
        bus.ds_gr_we       = we;
        bus.ds_pc          = pc;
    endtask

    task automatic sample();
        logic [18:0] e_op;
        logic [31:0] e_res;
        @(negedge clk);
        s_flag    = bus.alu_flag;
        s_ready   = m_occ && !m_cancel && (m_held || s_flag);
        s_allowin = !reset && !m_cancel && (!m_occ || (s_ready && bus.ms_allowin));
        s_accept  = bus.ds_to_es_valid && s_allowin && !bus.flush;
        m_in      = '{bus.ds_alu_op, bus.ds_src1, bus.ds_src2, bus.ds_dest, bus.ds_gr_we, bus.ds_pc};
        e_op      = (m_occ && !m_held) ? m_inst.op : 19'd0;
        e_res     = ref_alu(m_inst.op, m_inst.s1, m_inst.s2);
        chk("es_to_ms_valid", bus.es_to_ms_valid, s_ready);
        chk("es_allowin", bus.es_allowin, s_allowin);
        chk("alu_op_out", bus.alu_op_out, e_op);
        if (e_op != 0) begin
            chk("alu_src1_out", bus.alu_src1_out, m_inst.s1);
            chk("alu_src2_out", bus.alu_src2_out, m_inst.s2);
        end
        if (s_ready) begin
            chk("es_result", bus.es_result, e_res);
            chk("es_dest", bus.es_dest, m_inst.dest);
            chk("es_gr_we", bus.es_gr_we, m_inst.we);
            chk("es_pc", bus.es_pc, m_inst.pc);
        end
        chk("es_fwd_dest", bus.es_fwd_dest, (m_occ && !m_cancel && m_inst.we) ? m_inst.dest : 5'd0);
`ifdef ES_BYPASS_EN
        chk("es_fwd_ready", bus.es_fwd_ready, s_ready && m_inst.we);
        if (s_ready) chk("es_fwd_data", bus.es_fwd_data, e_res);
`else
        chk("es_fwd_ready", bus.es_fwd_ready, 0);
        chk("es_fwd_data", bus.es_fwd_data, 0);
`endif
    endtask

    task automatic advance();
        @(posedge clk);
        if (reset) begin
            m_occ = 0; m_cancel = 0; m_held = 0;
        end else begin
            if (m_cancel) begin
                if (s_flag) begin m_occ = 0; m_cancel = 0; end
            end else if (m_occ) begin
                if (bus.flush) begin
                    if (s_ready) m_occ = 0; else m_cancel = 1;
                end else if (s_ready && bus.ms_allowin) begin
                    m_occ = 0;
                end else if (s_ready) begin
                    m_held = 1;
                end
            end
            if (s_accept) begin
                m_occ = 1; m_held = 0; m_inst = m_in;
            end
        end
        #1;
    endtask

    task automatic hold_reset(input string tag);
        reset              = 1'b1;
        bus.ds_to_es_valid = 1'b0;
        bus.flush          = 1'b0;
        @(posedge clk);
        #1;
        m_occ = 0; m_cancel = 0; m_held = 0;
        @(negedge clk);
        chk({tag, "_valid"}, bus.es_to_ms_valid, 0);
        chk({tag, "_allowin"}, bus.es_allowin, 0);
        chk({tag, "_op"}, bus.alu_op_out, 0);
        chk({tag, "_src1"}, bus.alu_src1_out, 0);
        chk({tag, "_src2"}, bus.alu_src2_out, 0);
        chk({tag, "_result"}, bus.es_result, 0);
        chk({tag, "_dest"}, bus.es_dest, 0);
        chk({tag, "_gr_we"}, bus.es_gr_we, 0);
        chk({tag, "_pc"}, bus.es_pc, 0);
        chk({tag, "_fwd_dest"}, bus.es_fwd_dest, 0);
        chk({tag, "_fwd_ready"}, bus.es_fwd_ready, 0);
        chk({tag, "_fwd_data"}, bus.es_fwd_data, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int iss0;
        reset = 1'b1;
        bus.ms_allowin = 1'b1;
        set_ds(0, OP_ADD, 0, 0, 0, 0, 0);
        hold_reset("rst");

        // Add stream: 12 then 3 in consecutive cycles, stage always open.
        set_ds(1, OP_ADD, 5, 7, 5'd3, 1, 32'h100);
        sample(); chk("add_allowin_a", bus.es_allowin, 1); advance();
        set_ds(1, OP_ADD, 1, 2, 5'd4, 1, 32'h104);
        sample(); chk("add_res12", bus.es_result, 12); chk("add_allowin_b", bus.es_allowin, 1); advance();
        bus.ds_to_es_valid = 0;
        sample(); chk("add_res3", bus.es_result, 3); chk("add_valid3", bus.es_to_ms_valid, 1); advance();

        // Backpressure: sub 10-3 held for three cycles.
        set_ds(1, OP_SUB, 10, 3, 5'd5, 1, 32'h108);
        sample(); advance();
        bus.ds_to_es_valid = 0; bus.ms_allowin = 0;
        sample(); chk("sub_res7", bus.es_result, 7); advance();
        repeat (2) begin
            sample();
            chk("hold_res7", bus.es_result, 7);
            chk("hold_op0", bus.alu_op_out, 0);
            chk("hold_allowin0", bus.es_allowin, 0);
            advance();
        end
        bus.ms_allowin = 1;
        sample(); chk("hold_handoff", bus.es_to_ms_valid, 1); advance();
        sample(); chk("after_handoff", bus.es_to_ms_valid, 0); advance();

        // Signed divide with a waiting add behind it.
        set_ds(1, OP_DIV, 100, 7, 5'd6, 1, 32'h10c);
        sample(); advance();
        set_ds(1, OP_ADD, 20, 22, 5'd7, 1, 32'h110);
        n = 0;
        sample();
        while (!s_ready && n < 20) begin
            chk("div_wait_valid", bus.es_to_ms_valid, 0);
            chk("div_wait_allowin", bus.es_allowin, 0);
            advance(); sample(); n++;
        end
        chk("div_bound", n < 20, 1);
        chk("div_res14", bus.es_result, 14);
        advance();
        bus.ds_to_es_valid = 0;
        sample(); chk("div_next_add", bus.es_result, 42); advance();

        // Unsigned modulo captured under backpressure, one divider issue.
        set_ds(1, OP_MODU, 32'hFFFF_FFFF, 10, 5'd8, 1, 32'h114);
        sample(); advance();
        bus.ds_to_es_valid = 0; bus.ms_allowin = 0;
        iss0 = div_issues;
        n = 0;
        sample();
        while (!s_ready && n < 20) begin advance(); sample(); n++; end
        chk("modu_bound", n < 20, 1);
        chk("modu_res5", bus.es_result, 5);
        advance();
        repeat (3) begin
            sample(); chk("modu_hold5", bus.es_result, 5); chk("modu_op0", bus.alu_op_out, 0); advance();
        end
        bus.ms_allowin = 1;
        sample(); chk("modu_handoff", bus.es_to_ms_valid, 1); advance();
        sample(); chk("modu_issues", div_issues - iss0, 1); advance();

        // Flush mid-divide: drain without a result, flush during drain ignored.
        set_ds(1, OP_DIV, 100, 7, 5'd9, 1, 32'h118);
        sample(); advance();
        bus.ds_to_es_valid = 0; bus.flush = 1;
        sample(); chk("flush_valid0", bus.es_to_ms_valid, 0); advance();
        n = 0;
        sample();
        while (m_occ && n < 20) begin
            chk("drain_valid0", bus.es_to_ms_valid, 0);
            chk("drain_op", bus.alu_op_out, OP_DIV);
            advance(); bus.flush = 0; sample(); n++;
        end
        bus.flush = 0;
        chk("drain_bound", n < 20, 1);
        advance();
        set_ds(1, OP_ADD, 1, 1, 5'd10, 1, 32'h11c);
        sample(); advance();
        bus.ds_to_es_valid = 0;
        sample(); chk("post_flush_add2", bus.es_result, 2); advance();

        // Reset in the middle of a divide.
        set_ds(1, OP_DIV, 100, 7, 5'd11, 1, 32'h120);
        sample(); advance();
        bus.ds_to_es_valid = 0;
        sample(); advance();
        hold_reset("rst_mid_div");
        sample(); chk("post_reset_allowin", bus.es_allowin, 1); advance();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            logic [18:0] op;
            logic [31:0] a, b;
            int r;
            r = $urandom_range(0, 9);
            op = (r < 4) ? OP_ADD : (r < 6) ? OP_SUB : (r == 6) ? OP_DIV :
                 (r == 7) ? OP_DIVU : (r == 8) ? OP_MOD : OP_MODU;
            a = $urandom;
            b = $urandom;
            if (is_div_op(op)) begin
                b = b | 32'd1;
                if (b == 32'hFFFF_FFFF) b = 32'd3;
            end
            set_ds($urandom_range(0, 3) != 0, op, a, b, 5'($urandom), 1'($urandom), $urandom);
            bus.ms_allowin = ($urandom_range(0, 3) != 0);
            bus.flush      = ($urandom_range(0, 15) == 0);
            sample();
            advance();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
